// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder: operation
// encodings, default geometry and the carry-in selection helper.
package cla_pkg;

  localparam int CLA_WIDTH = 32;
  localparam int CLA_SEG   = 16;
  localparam int CLA_GRP   = 4;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_ADDC = 2'b10;
  localparam logic [1:0] OP_SUBB = 2'b11;

  // Subtracting ops invert b and report lt/ltu.
  function automatic logic op_is_sub(input logic [1:0] op);
    return op[0];
  endfunction

  // Carry into bit 0: the +1 of two's complement for SUB, and the
  // borrow for SUBB is folded in as an inverted carry.
  function automatic logic op_carry0(input logic [1:0] op, input logic cin);
    logic c;
    case (op)
      OP_ADD:  c = 1'b0;
      OP_SUB:  c = 1'b1;
      OP_ADDC: c = cin;
      default: c = ~cin;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cla_seg.sv
// Combinational SEG-bit adder segment built from 4-bit carry-lookahead
// groups; group carries ripple from one group to the next.
module cla_seg
  import cla_pkg::*;
#(
  parameter int SEG = CLA_SEG
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           cout,
  output logic           c_msb
);

  localparam int NGRP = SEG / CLA_GRP;

  logic [SEG-1:0] g;
  logic [SEG-1:0] p;
  logic [SEG:0]   cy;

  assign g = a & b;
  assign p = a ^ b;

  // Per-group lookahead: every carry of a group is formed directly from
  // the group's generate/propagate terms and the carry entering the group.
  always_comb begin
    logic [SEG:0] c;
    logic [3:0]   gg;
    logic [3:0]   pp;
    logic         c0;
    c    = '0;
    gg   = '0;
    pp   = '0;
    c0   = 1'b0;
    c[0] = cin;
    for (int j = 0; j < NGRP; j++) begin
      gg = g[j*CLA_GRP +: CLA_GRP];
      pp = p[j*CLA_GRP +: CLA_GRP];
      c0 = c[j*CLA_GRP];
      c[j*CLA_GRP+1] = gg[0] | (pp[0] & c0);
      c[j*CLA_GRP+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c0);
      c[j*CLA_GRP+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                     | (pp[2] & pp[1] & pp[0] & c0);
      c[j*CLA_GRP+4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                     | (pp[3] & pp[2] & pp[1] & gg[0]) | ((&pp) & c0);
    end
    cy = c;
  end

  assign s     = p ^ cy[SEG-1:0];
  assign cout  = cy[SEG];
  assign c_msb = cy[SEG-1];

endmodule

// File: rtl/pipe_cla.sv
// Pipelined adder/subtractor resolving one SEG-bit segment of the carry
// chain per stage. Operands for unresolved segments and already-resolved
// low result slices travel together in the stage registers so the whole
// result leaves the last stage at once.
//
// Handshake: a beat moves on a rising edge when valid && ready on that
// interface. The only back-pressure point is the output stage: when it
// holds a beat that is not being taken, every stage freezes and in_ready
// drops; otherwise every stage advances (empty stages carry bubbles that
// collapse only at the output), and an input beat may be accepted on the
// same edge that the output beat is taken.
module pipe_cla
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int SEG   = CLA_SEG
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             lt,
  output logic             ltu
);

  localparam int N = WIDTH / SEG;

  // Stage registers: entry k holds a beat whose segments 0..k are resolved.
  logic             st_v   [N];
  logic [WIDTH-1:0] st_a   [N];
  logic [WIDTH-1:0] st_b   [N];
  logic [WIDTH-1:0] st_s   [N];
  logic             st_c   [N];
  logic             st_cm  [N];
  logic             st_sub [N];

  // Inputs seen by each stage's segment adder.
  logic [WIDTH-1:0] stg_a   [N];
  logic [WIDTH-1:0] stg_b   [N];
  logic [WIDTH-1:0] stg_s   [N];
  logic             stg_c   [N];
  logic             stg_sub [N];
  logic             stg_v   [N];

  // Segment adder results and the merged partial sums.
  logic [SEG-1:0]   seg_s  [N];
  logic             seg_co [N];
  logic             seg_cm [N];
  logic [WIDTH-1:0] nxt_s  [N];

  logic stall;

  assign stall    = st_v[N-1] & ~out_ready;
  assign in_ready = ~stall;

  for (genvar k = 0; k < N; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign stg_v[k]   = in_valid;
      assign stg_a[k]   = a;
      assign stg_b[k]   = op_is_sub(op) ? ~b : b;
      assign stg_s[k]   = '0;
      assign stg_c[k]   = op_carry0(op, cin);
      assign stg_sub[k] = op_is_sub(op);
    end else begin : g_next
      assign stg_v[k]   = st_v[k-1];
      assign stg_a[k]   = st_a[k-1];
      assign stg_b[k]   = st_b[k-1];
      assign stg_s[k]   = st_s[k-1];
      assign stg_c[k]   = st_c[k-1];
      assign stg_sub[k] = st_sub[k-1];
    end

    cla_seg #(.SEG(SEG)) u_seg (
      .a     (stg_a[k][k*SEG +: SEG]),
      .b     (stg_b[k][k*SEG +: SEG]),
      .cin   (stg_c[k]),
      .s     (seg_s[k]),
      .cout  (seg_co[k]),
      .c_msb (seg_cm[k])
    );

    // Bits above the resolved slices are always zero, so OR-in is a merge.
    assign nxt_s[k] = stg_s[k] | (WIDTH'(seg_s[k]) << (k*SEG));
  end

  // All stages advance together unless the output beat is being held.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N; k++) begin
        st_v[k]   <= 1'b0;
        st_a[k]   <= '0;
        st_b[k]   <= '0;
        st_s[k]   <= '0;
        st_c[k]   <= 1'b0;
        st_cm[k]  <= 1'b0;
        st_sub[k] <= 1'b0;
      end
    end else if (!stall) begin
      for (int k = 0; k < N; k++) begin
        st_v[k]   <= stg_v[k];
        st_a[k]   <= stg_a[k];
        st_b[k]   <= stg_b[k];
        st_s[k]   <= nxt_s[k];
        st_c[k]   <= seg_co[k];
        st_cm[k]  <= seg_cm[k];
        st_sub[k] <= stg_sub[k];
      end
    end
  end

  // Flags derive from registered state only, so they hold while stalled.
  assign out_valid = st_v[N-1];
  assign sum       = st_s[N-1];
  assign cout      = st_c[N-1];
  assign ovf       = st_cm[N-1] ^ st_c[N-1];
  assign lt        = st_sub[N-1] & (st_s[N-1][WIDTH-1] ^ ovf);
  assign ltu       = st_sub[N-1] & ~st_c[N-1];

endmodule

// File: doc/pipe_cla.md
PIPE_CLA -- requirements
Module: pipe_cla

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; WIDTH SHALL be a multiple of SEG.
REQ-002 SHALL have parameter SEG, default 16, segment width resolved per pipeline stage; SEG SHALL be a multiple of 4.
REQ-003 SHALL have port clock  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand beat offered.
REQ-006 SHALL have port in_ready  output  1  operand beat accepted when in_valid && in_ready.
REQ-007 SHALL have port a, b  input  WIDTH each  operands.
REQ-008 SHALL have port op  input  2  00 ADD, 01 SUB, 10 ADDC (add + cin), 11 SUBB (subtract - cin).
REQ-009 SHALL have port cin  input  1  carry/borrow in; ignored for ADD/SUB.
REQ-010 SHALL have port out_valid  output  1  result beat present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-012 SHALL have port sum  output  WIDTH  result.
REQ-013 SHALL have ports cout, ovf, lt, ltu  output  1 each  carry-out, signed overflow, signed a<b, unsigned a<b.

Function
REQ-014 SHALL resolve the carry chain one SEG-bit segment per stage; latency SHALL be N = WIDTH/SEG cycles from accept to out_valid.
REQ-015 SHALL use 4-bit carry-lookahead groups inside each segment; segment carry-out SHALL be registered into the next stage.
REQ-016 SHALL form the b operand as ~b for SUB/SUBB, b otherwise; carry into bit 0 SHALL be 0 (ADD), 1 (SUB), cin (ADDC), ~cin (SUBB).
REQ-017 SHALL carry the pending upper operand slices and low result slices forward in stage registers (skew buffering), so that all WIDTH result bits leave together.
REQ-018 ovf SHALL equal carry into MSB XOR carry out of MSB; cout SHALL be the raw MSB carry-out, not inverted for subtraction.
REQ-019 lt SHALL equal sum[WIDTH-1] XOR ovf; ltu SHALL equal ~cout; lt/ltu SHALL be 0 for ADD/ADDC.
REQ-020 SHALL accept one beat per cycle with no bubbles while out_ready is high (full throughput).
REQ-021 SHALL stall all stages together when out_valid && !out_ready; in_ready = !stall.
REQ-022 SHALL hold sum, flags and out_valid stable while stalled; SHALL NOT drop or duplicate beats.
REQ-023 SHALL propagate in-flight valid bits through empty stages while the output stage is empty (bubbles collapse only at the output).
REQ-024 SHALL accept a new beat on the same cycle the output beat is taken (simultaneous in/out handshake).
REQ-025 SHALL wrap modulo 2^WIDTH; no saturation.
REQ-026 For N=1 SHALL behave as a single registered adder with latency 1.

Reset
REQ-027 On reset_n low, all stage valid bits, out_valid, sum, cout, ovf, lt, ltu SHALL clear to 0 immediately.
REQ-028 Reset mid-operation SHALL discard all in-flight beats; in_ready SHALL be 1 from the first cycle after release.

Structure
REQ-029 Shared package cla_pkg SHALL hold op encodings (OP_ADD, OP_SUB, OP_ADDC, OP_SUBB) and default WIDTH/SEG constants.
REQ-030 A combinational sub-module cla_seg (SEG-bit, 4-bit lookahead groups, ports a, b, cin, s, cout, c_msb) SHALL be instantiated once per stage.

Verification (WIDTH=32, SEG=16, N=2)
REQ-031 ADD a=0x0000FFFF, b=0x00000001 -> after 2 cycles sum=0x00010000, cout=0, ovf=0 (cross-segment carry).
REQ-032 SUB a=0x80000000, b=0x00000001 -> sum=0x7FFFFFFF, ovf=1, lt=1, ltu=0, cout=1.
REQ-033 ADDC a=0xFFFFFFFF, b=0, cin=1 -> sum=0, cout=1; SUBB a=5, b=5, cin=1 -> sum=0xFFFFFFFF, lt=1, ltu=1.
REQ-034 Back-to-back 8 beats, out_ready=1 -> 8 results on consecutive cycles in order, in_ready constant 1.
REQ-035 out_ready held 0 for 5 cycles with continuous in_valid -> in_ready falls when output full, outputs frozen, all beats later emerge in order with none lost.
REQ-036 reset_n pulsed low with 2 beats in flight -> out_valid=0 immediately, no stale result after release.
